axim_controller: RTL and testbench



---
 rtl/axim_controller.sv | 84 ++++++++
 tb/tb_axim_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/axim_controller.sv
// Splits one read request into four contiguous near-equal sub-requests,
// one per Zynq HP AXI master port, with registered strobes, sizes and addresses.
module axim_controller #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int TX_SIZE_WIDTH      = 10
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx_req,
    input  logic [TX_SIZE_WIDTH-1:0]      rx_size,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] rx_addr,
    output logic                          axim_hp0_rx_req,
    output logic [TX_SIZE_WIDTH-1:0]      axim_hp0_rx_size,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] axim_hp0_rx_addr,
    output logic                          axim_hp1_rx_req,
    output logic [TX_SIZE_WIDTH-1:0]      axim_hp1_rx_size,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] axim_hp1_rx_addr,
    output logic                          axim_hp2_rx_req,
    output logic [TX_SIZE_WIDTH-1:0]      axim_hp2_rx_size,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] axim_hp2_rx_addr,
    output logic                          axim_hp3_rx_req,
    output logic [TX_SIZE_WIDTH-1:0]      axim_hp3_rx_size,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] axim_hp3_rx_addr
);

    localparam int unsigned BYTES_PER_BEAT = C_M_AXI_DATA_WIDTH / 8;

    logic [TX_SIZE_WIDTH-1:0]      quot;
    logic [1:0]                    rem;
    logic [TX_SIZE_WIDTH-1:0]      split_size [4];
    logic [C_M_AXI_ADDR_WIDTH-1:0] split_addr [4];

    logic [3:0]                    req_q;
    logic [TX_SIZE_WIDTH-1:0]      size_q [4];
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q [4];

    always_comb begin
        quot = rx_size >> 2;
        rem  = rx_size[1:0];
        for (int unsigned n = 0; n < 4; n++) begin
            split_size[n] = quot + ((n < 32'(rem)) ? TX_SIZE_WIDTH'(1) : '0);
        end
        // Each chunk starts where the previous one ends; wraps modulo 2^ADDR_WIDTH.
        split_addr[0] = rx_addr;
        for (int unsigned n = 1; n < 4; n++) begin
            split_addr[n] = split_addr[n-1]
                          + C_M_AXI_ADDR_WIDTH'(split_size[n-1])
                          * C_M_AXI_ADDR_WIDTH'(BYTES_PER_BEAT);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q <= '0;
            for (int unsigned n = 0; n < 4; n++) begin
                size_q[n] <= '0;
                addr_q[n] <= '0;
            end
        end else if (rx_req) begin
            for (int unsigned n = 0; n < 4; n++) begin
                req_q[n]  <= (split_size[n] != '0);
                size_q[n] <= split_size[n];
                addr_q[n] <= split_addr[n];
            end
        end else begin
            req_q <= '0;
        end
    end

    assign axim_hp0_rx_req  = req_q[0];
    assign axim_hp1_rx_req  = req_q[1];
    assign axim_hp2_rx_req  = req_q[2];
    assign axim_hp3_rx_req  = req_q[3];
    assign axim_hp0_rx_size = size_q[0];
    assign axim_hp1_rx_size = size_q[1];
    assign axim_hp2_rx_size = size_q[2];
    assign axim_hp3_rx_size = size_q[3];
    assign axim_hp0_rx_addr = addr_q[0];
    assign axim_hp1_rx_addr = addr_q[1];
    assign axim_hp2_rx_addr = addr_q[2];
    assign axim_hp3_rx_addr = addr_q[3];

endmodule

// File: tb/tb_axim_controller.sv
// Self-checking bench for axim_controller: directed table vectors, reset
// corner cases and randomized requests against a closed-form split model.
module tb_axim_controller;

    logic        clk;
    logic        resetn;
    logic        rx_req;
    logic [9:0]  rx_size;
    logic [31:0] rx_addr;
    logic        hp0_req, hp1_req, hp2_req, hp3_req;
    logic [9:0]  hp0_size, hp1_size, hp2_size, hp3_size;
    logic [31:0] hp0_addr, hp1_addr, hp2_addr, hp3_addr;

    int checks = 0;
    int errors = 0;

    axim_controller #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(64),
        .TX_SIZE_WIDTH(10)
    ) dut (
        .clk(clk), .resetn(resetn),
        .rx_req(rx_req), .rx_size(rx_size), .rx_addr(rx_addr),
        .axim_hp0_rx_req(hp0_req), .axim_hp0_rx_size(hp0_size), .axim_hp0_rx_addr(hp0_addr),
        .axim_hp1_rx_req(hp1_req), .axim_hp1_rx_size(hp1_size), .axim_hp1_rx_addr(hp1_addr),
        .axim_hp2_rx_req(hp2_req), .axim_hp2_rx_size(hp2_size), .axim_hp2_rx_addr(hp2_addr),
        .axim_hp3_rx_req(hp3_req), .axim_hp3_rx_size(hp3_size), .axim_hp3_rx_addr(hp3_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       o_req;
    logic [3:0][9:0]  o_size;
    logic [3:0][31:0] o_addr;
    assign o_req  = {hp3_req, hp2_req, hp1_req, hp0_req};
    assign o_size = {hp3_size, hp2_size, hp1_size, hp0_size};
    assign o_addr = {hp3_addr, hp2_addr, hp1_addr, hp0_addr};

    // Reference state: what the outputs should show after the last edge.
    logic [3:0]       m_req;
    logic [3:0][9:0]  m_size;
    logic [3:0][31:0] m_addr;

    typedef struct packed {
        logic [9:0]       size;
        logic [31:0]      addr;
        logic [3:0][9:0]  es;
        logic [3:0][31:0] ea;
        logic [3:0]       ereq;
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mk(input logic [9:0] size, input logic [31:0] addr,
                                input logic [9:0] s0, s1, s2, s3,
                                input logic [31:0] a0, a1, a2, a3,
                                input logic [3:0] ereq);
        vec_t v;
        v.size = size; v.addr = addr;
        v.es[0] = s0; v.es[1] = s1; v.es[2] = s2; v.es[3] = s3;
        v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
        v.ereq = ereq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] er,
                                 input logic [3:0][9:0] es, input logic [3:0][31:0] ea);
        for (int n = 0; n < 4; n++) begin
            check($sformatf("%s hp%0d req", tag, n), 32'(o_req[n]), 32'(er[n]));
            check($sformatf("%s hp%0d size", tag, n), 32'(o_size[n]), 32'(es[n]));
            check($sformatf("%s hp%0d addr", tag, n), o_addr[n], ea[n]);
        end
    endtask

    // Port n covers beats [n*q + min(n,r), ...) of the transfer, length q + (n<r).
    task automatic model_step(input logic req, input logic [9:0] size, input logic [31:0] addr);
        int unsigned q, r, beats_before;
        if (!req) begin
            m_req = '0;
            return;
        end
        q = int'(size) / 4;
        r = int'(size) % 4;
        for (int n = 0; n < 4; n++) begin
            beats_before = n * q + ((n < r) ? n : r);
            m_size[n] = 10'(q + ((n < r) ? 1 : 0));
            m_addr[n] = addr + 32'(beats_before * 8);
            m_req[n]  = (m_size[n] != 0);
        end
    endtask

    task automatic model_reset();
        m_req = '0; m_size = '0; m_addr = '0;
    endtask

    task automatic apply(input logic req, input logic [9:0] size, input logic [31:0] addr);
        @(negedge clk);
        rx_req = req; rx_size = size; rx_addr = addr;
        @(posedge clk);
        #1;
        model_step(req, size, addr);
    endtask

    initial begin
        vecs[0] = mk(10'd10, 32'h0000_1000, 10'd3, 10'd3, 10'd2, 10'd2,
                     32'h0000_1000, 32'h0000_1018, 32'h0000_1030, 32'h0000_1040, 4'b1111);
        vecs[1] = mk(10'd2, 32'h0000_2000, 10'd1, 10'd1, 10'd0, 10'd0,
                     32'h0000_2000, 32'h0000_2008, 32'h0000_2010, 32'h0000_2010, 4'b0011);
        vecs[2] = mk(10'd0, 32'h0000_3000, 10'd0, 10'd0, 10'd0, 10'd0,
                     32'h0000_3000, 32'h0000_3000, 32'h0000_3000, 32'h0000_3000, 4'b0000);
        vecs[3] = mk(10'd1023, 32'hDEAD_BEEF, 10'd256, 10'd256, 10'd256, 10'd255,
                     32'hDEAD_BEEF, 32'hDEAD_C6EF, 32'hDEAD_CEEF, 32'hDEAD_D6EF, 4'b1111);
        vecs[4] = mk(10'd4, 32'hFFFF_FFF8, 10'd1, 10'd1, 10'd1, 10'd1,
                     32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0008, 32'h0000_0010, 4'b1111);

        resetn = 1'b0; rx_req = 1'b1; rx_size = 10'd10; rx_addr = 32'h1000;
        model_reset();
        #2;
        check_outputs("reset", m_req, m_size, m_addr);
        @(posedge clk); #1;
        check_outputs("reset held", m_req, m_size, m_addr);
        @(negedge clk);
        rx_req = 1'b0;
        resetn = 1'b1;
        apply(1'b0, 10'd0, 32'h0);
        check_outputs("post reset idle", m_req, m_size, m_addr);

        for (int i = 0; i < 5; i++) begin
            apply(1'b1, vecs[i].size, vecs[i].addr);
            check_outputs($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].es, vecs[i].ea);
            apply(1'b0, 10'd0, 32'h0);
            check_outputs($sformatf("vec%0d hold", i), 4'b0000, vecs[i].es, vecs[i].ea);
        end

        apply(1'b1, 10'd8, 32'h0000_0000);
        check_outputs("b2b first", m_req, m_size, m_addr);
        apply(1'b1, 10'd4, 32'h0000_0100);
        check_outputs("b2b second", m_req, m_size, m_addr);
        apply(1'b0, 10'd0, 32'h0);
        check_outputs("b2b idle", m_req, m_size, m_addr);

        apply(1'b1, 10'd9, 32'h0000_4000);
        check_outputs("pre midreset", m_req, m_size, m_addr);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check_outputs("midreset async", m_req, m_size, m_addr);
        @(negedge clk);
        resetn = 1'b1;
        apply(1'b1, 10'd7, 32'h0000_5004);
        check_outputs("after midreset", m_req, m_size, m_addr);

        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic [9:0] s;
            r = ($urandom_range(0, 3) != 0);
            s = (i % 17 == 0) ? 10'($urandom_range(0, 4)) : 10'($urandom);
            apply(r, s, $urandom);
            check_outputs($sformatf("rand%0d", i), m_req, m_size, m_addr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
